// File: rtl/img2col_map_seq.sv
// img2col_map_seq: img2col PU-array mapping sequencer (BUFFER prefill then handshaked WORK sweep); MAP_SEQ_STALL_CNT_EN adds stall_cnt
module img2col_map_seq #(
  parameter int IMG_ROWS = 28,
  parameter int NUM_PU = 28,
  parameter int KERNEL = 5,
  parameter int CNT_W = $clog2((IMG_ROWS > NUM_PU) ? IMG_ROWS : NUM_PU) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [NUM_PU-1:0] nb_ready,
  output logic [CNT_W-1:0] pu_addr,
  output logic [CNT_W-1:0] pu_no,
  output logic [CNT_W-1:0] row_no,
  output logic [CNT_W-1:0] round,
  output logic             busy,
  output logic             done
`ifdef MAP_SEQ_STALL_CNT_EN
  ,
  output logic [31:0]      stall_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, BUFFER, WORK, DONE} state_t;
  localparam logic [CNT_W-1:0] A_LAST = CNT_W'(KERNEL - 1);
  localparam logic [CNT_W-1:0] P_LAST = CNT_W'(NUM_PU - 1);
  localparam logic [CNT_W-1:0] R_BUF = CNT_W'(KERNEL - 2);
  localparam logic [CNT_W-1:0] R_LAST = CNT_W'(IMG_ROWS - KERNEL);
  state_t state, state_n;
  logic [CNT_W-1:0] addr_n, pu_n, row_n, round_n, step_addr, step_pu, step_row;
  logic [NUM_PU-1:0] rdy_vec;
  logic slot_end, row_end, rdy, stall;
  assign slot_end = pu_addr == A_LAST;
  assign row_end = slot_end && pu_no == P_LAST;
  assign rdy_vec = nb_ready >> pu_no;
  assign rdy = rdy_vec[0];
  assign stall = state == WORK && slot_end && !rdy;
  assign step_addr = slot_end ? '0 : pu_addr + 1'b1;
  assign step_pu = slot_end ? (row_end ? '0 : pu_no + 1'b1) : pu_no;
  assign step_row = row_end ? row_no + 1'b1 : row_no;
  assign busy = state == BUFFER || state == WORK;
  assign done = state == DONE;
  always_comb begin
    state_n = state;
    addr_n = pu_addr;
    pu_n = pu_no;
    row_n = row_no;
    round_n = round;
    if (abort) begin
      state_n = IDLE;
      addr_n = '0;
      pu_n = '0;
      row_n = '0;
      round_n = '0;
    end else begin
      unique case (state)
        IDLE: begin
          state_n = start ? BUFFER : IDLE;
          addr_n = '0;
          pu_n = '0;
          row_n = '0;
          round_n = '0;
        end
        BUFFER: begin
          state_n = (row_end && row_no == R_BUF) ? WORK : BUFFER;
          addr_n = step_addr;
          pu_n = step_pu;
          row_n = step_row;
          round_n = '0;
        end
        WORK: begin
          if (!stall && row_end && round == R_LAST) state_n = DONE;
          else if (!stall) begin
            addr_n = step_addr;
            pu_n = step_pu;
            row_n = step_row;
            round_n = row_end ? round + 1'b1 : round;
          end
        end
        DONE: begin
          state_n = IDLE;
          addr_n = '0;
          pu_n = '0;
          row_n = '0;
          round_n = '0;
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pu_addr <= '0;
      pu_no <= '0;
      row_no <= '0;
      round <= '0;
    end else begin
      state <= state_n;
      pu_addr <= addr_n;
      pu_no <= pu_n;
      row_no <= row_n;
      round <= round_n;
    end
  end
`ifdef MAP_SEQ_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || (state == IDLE && start && !abort)) stall_cnt <= '0;
    else if (stall && !abort && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 1'b1;
  end
`endif
endmodule
